// File: rtl/axil_uart_master.sv
// AXI4-Lite initiator: one command in, one AXI-Lite write or read out, one response back; optional
// watchdog flag under `AXIL_UART_MASTER_TIMEOUT_EN. Latency: command to AXI valid 1 cycle; backpressure: cmd_ready only in IDLE.
module axil_uart_master #(
    parameter int P_M_AXI_DATA_WIDTH = 32,
    parameter int P_M_AXI_ADDR_WIDTH = 16,
    parameter int P_TIMEOUT_CYCLES   = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [P_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [P_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [P_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic                          timeout
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t                          state, state_nxt;
    logic                            aw_done, w_done;
    logic [P_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [P_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic                            write_q;
    logic [P_M_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                      resp_q;
    logic                            cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign aw_hs  = m_axi_awvalid & m_axi_awready;
    assign w_hs   = m_axi_wvalid & m_axi_wready;
    assign b_hs   = m_axi_bvalid & m_axi_bready;
    assign ar_hs  = m_axi_arvalid & m_axi_arready;
    assign r_hs   = m_axi_rvalid & m_axi_rready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_AW_W : RD_AR;
            WR_AW_W: if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_B;
            WR_B:    if (m_axi_bvalid) state_nxt = RSP;
            RD_AR:   if (m_axi_arready) state_nxt = RD_R;
            RD_R:    if (m_axi_rvalid) state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state == IDLE);
        m_axi_awvalid = (state == WR_AW_W) && !aw_done;
        m_axi_wvalid  = (state == WR_AW_W) && !w_done;
        m_axi_bready  = (state == WR_B);
        m_axi_arvalid = (state == RD_AR);
        m_axi_rready  = (state == RD_R);
        rsp_valid     = (state == RSP);
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign rsp_write    = write_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_resp     = resp_q;

    // Command capture, per-channel write completion, and response capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                write_q <= cmd_write;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (b_hs) begin
                rdata_q <= '0;
                resp_q  <= m_axi_bresp;
            end
            if (r_hs) begin
                rdata_q <= m_axi_rdata;
                resp_q  <= m_axi_rresp;
            end
        end
    end

`ifdef AXIL_UART_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        waiting;
    logic        restart;

    assign waiting = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
    assign restart = (state_nxt != state) || aw_hs || w_hs || b_hs || ar_hs || r_hs;

    // Flag is informational only: valids stay up and the FSM keeps waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (restart)
                wait_cnt <= '0;
            else if (waiting && wait_cnt != 16'hFFFF)
                wait_cnt <= wait_cnt + 16'd1;
            if (waiting && !restart && wait_cnt == 16'(P_TIMEOUT_CYCLES - 1))
                timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axil_uart_master.sv
// Self-checking bench for axil_uart_master: scripted AXI-Lite slave per scenario, response scoreboard.
module tb_axil_uart_master;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] awaddr, araddr;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [31:0] wdata;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0, rready;
    logic        timeout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    axil_uart_master #(.P_TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Presents one command for exactly one accepting edge and records its expected response.
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input exp_t e);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0; cmd_wdata = '0;
    endtask

    task automatic slave_b(input logic [1:0] resp);
        int n = 0;
        while (!bready && n < 50) begin tick(); n++; end
        if (!bready) begin checks++; errors++; $display("FAIL b_wait: bready=%b required 1", bready); end
        bvalid = 1'b1; bresp = resp;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic slave_r(input logic [31:0] d, input logic [1:0] resp);
        int n = 0;
        while (!rready && n < 50) begin tick(); n++; end
        if (!rready) begin checks++; errors++; $display("FAIL r_wait: rready=%b required 1", rready); end
        rvalid = 1'b1; rdata = d; rresp = resp;
        tick();
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    endtask

    // Waits (bounded) for rsp_valid and returns the observed payload without consuming it.
    task automatic wait_rsp(output logic ok, output logic w, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        ok = rsp_valid; w = rsp_write; d = rsp_rdata; r = rsp_resp;
        if (!ok) begin checks++; errors++; $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid); end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 7'b1000000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 1000000",
                               {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        checks++;
        if ({awaddr, wdata, rsp_rdata, rsp_resp, rsp_write, timeout} !== '0) begin
            errors++; $display("FAIL reset_data: awaddr=%h wdata=%h rdata=%h resp=%b w=%b to=%b required 0",
                               awaddr, wdata, rsp_rdata, rsp_resp, rsp_write, timeout);
        end
        @(negedge clock); reset = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait;
        logic ok, w; logic [31:0] d; logic [1:0] r; exp_t e;
        awready = 1'b1; wready = 1'b1;
        issue(1'b1, 16'h0004, 32'h0000000C, '{w: 1'b1, d: 32'h0, r: 2'b00});
        checks++;
        if ({awvalid, wvalid, cmd_ready, bready} !== 4'b1100 || awaddr !== 16'h0004 || wdata !== 32'hC) begin
            errors++; $display("FAIL wr_n1: aw=%b w=%b crdy=%b br=%b addr=%h data=%h required 1100 0004 0000000c",
                               awvalid, wvalid, cmd_ready, bready, awaddr, wdata);
        end
        tick();
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++; $display("FAIL wr_n2: aw=%b w=%b br=%b required 001", awvalid, wvalid, bready);
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || bready !== 1'b0) begin
            errors++; $display("FAIL wr_n3: rsp_valid=%b bready=%b required 1 0", rsp_valid, bready);
        end
        wait_rsp(ok, w, d, r);
        e = sb.pop_front();
        checks++;
        if (ok && {w, d, r} !== e) begin
            errors++; $display("FAIL wr_rsp: got w=%b d=%h r=%b required w=%b d=%h r=%b", w, d, r, e.w, e.d, e.r);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL wr_done: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        end
        awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_read;
        logic ok, w; logic [31:0] d; logic [1:0] r; exp_t e;
        issue(1'b0, 16'h0000, 32'hFFFFFFFF, '{w: 1'b0, d: 32'h00000041, r: 2'b00});
        checks++;
        if ({arvalid, rready, awvalid, wvalid} !== 4'b1000 || araddr !== 16'h0000) begin
            errors++; $display("FAIL rd_ar: ar=%b rr=%b aw=%b w=%b addr=%h required 1000 0000",
                               arvalid, rready, awvalid, wvalid, araddr);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({arvalid, rready} !== 2'b01) begin
                errors++; $display("FAIL rd_wait%0d: ar=%b rr=%b required 01", i, arvalid, rready);
            end
            tick();
        end
        rvalid = 1'b1; rdata = 32'h00000041; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if (rready !== 1'b0) begin errors++; $display("FAIL rd_rready_drop: rready=%b required 0", rready); end
        wait_rsp(ok, w, d, r);
        e = sb.pop_front();
        checks++;
        if (ok && {w, d, r} !== e) begin
            errors++; $display("FAIL rd_rsp: got w=%b d=%h r=%b required w=%b d=%h r=%b", w, d, r, e.w, e.d, e.r);
        end
        tick();
    endtask

    task automatic test_aw_stall;
        logic ok, w; logic [31:0] d; logic [1:0] r; exp_t e;
        wready = 1'b1;
        issue(1'b1, 16'h0010, 32'h000000A5, '{w: 1'b1, d: 32'h0, r: 2'b00});
        checks++;
        if ({awvalid, wvalid} !== 2'b11) begin
            errors++; $display("FAIL st_start: aw=%b w=%b required 11", awvalid, wvalid);
        end
        tick();
        wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({awvalid, wvalid, bready} !== 3'b100 || awaddr !== 16'h0010) begin
                errors++; $display("FAIL st_hold%0d: aw=%b w=%b br=%b addr=%h required 100 0010",
                                   i, awvalid, wvalid, bready, awaddr);
            end
            tick();
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            errors++; $display("FAIL st_b: aw=%b w=%b br=%b required 001", awvalid, wvalid, bready);
        end
        slave_b(2'b00);
        wait_rsp(ok, w, d, r);
        e = sb.pop_front();
        checks++;
        if (ok && {w, d, r} !== e) begin
            errors++; $display("FAIL st_rsp: got w=%b d=%h r=%b required w=%b d=%h r=%b", w, d, r, e.w, e.d, e.r);
        end
        tick();
    endtask

    task automatic test_error_resp;
        logic ok, w; logic [31:0] d; logic [1:0] r; exp_t e;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        rsp_ready = 1'b0;
        issue(1'b1, 16'h0008, 32'h12345678, '{w: 1'b1, d: 32'h0, r: 2'b10});
        slave_b(2'b10);
        wait_rsp(ok, w, d, r);
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || {rsp_write, rsp_rdata, rsp_resp} !== e) begin
                errors++; $display("FAIL err_hold%0d: v=%b crdy=%b w=%b d=%h r=%b required 1 0 %b %h %b",
                                   i, rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp, e.w, e.d, e.r);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        issue(1'b0, 16'h000C, 32'h0, '{w: 1'b0, d: 32'hDEADBEEF, r: 2'b11});
        slave_r(32'hDEADBEEF, 2'b11);
        wait_rsp(ok, w, d, r);
        e = sb.pop_front();
        checks++;
        if (ok && {w, d, r} !== e) begin
            errors++; $display("FAIL err_rd: got w=%b d=%h r=%b required w=%b d=%h r=%b", w, d, r, e.w, e.d, e.r);
        end
        tick();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic ok, w; logic [31:0] d; logic [1:0] r; exp_t e;
        awready = 1'b1; wready = 1'b1;
        issue(1'b1, 16'h0020, 32'h55AA55AA, '{w: 1'b1, d: 32'h0, r: 2'b00});
        tick();
        checks++;
        if (bready !== 1'b1) begin errors++; $display("FAIL rm_wrb: bready=%b required 1", bready); end
        #2 reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
            errors++; $display("FAIL rm_async: got %b required 0000001",
                               {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
        end
        @(negedge clock); reset = 1'b0;
        tick();
        issue(1'b1, 16'h0024, 32'h00000077, '{w: 1'b1, d: 32'h0, r: 2'b01});
        checks++;
        if (awaddr !== 16'h0024 || wdata !== 32'h77) begin
            errors++; $display("FAIL rm_next_aw: addr=%h data=%h required 0024 00000077", awaddr, wdata);
        end
        slave_b(2'b01);
        wait_rsp(ok, w, d, r);
        e = sb.pop_front();
        checks++;
        if (ok && {w, d, r} !== e) begin
            errors++; $display("FAIL rm_rsp: got w=%b d=%h r=%b required w=%b d=%h r=%b", w, d, r, e.w, e.d, e.r);
        end
        tick();
        awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_timeout;
        logic exp_to;
`ifdef AXIL_UART_MASTER_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        arready = 1'b0;
        issue(1'b0, 16'h0030, 32'h0, '{w: 1'b0, d: 32'h0, r: 2'b00});
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL to_early: timeout=%b required 0", timeout); end
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (timeout !== exp_to || arvalid !== 1'b1 || araddr !== 16'h0030) begin
            errors++; $display("FAIL to_flag: timeout=%b arvalid=%b addr=%h required %b 1 0030",
                               timeout, arvalid, araddr, exp_to);
        end
        #2 reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if (timeout !== 1'b0 || arvalid !== 1'b0) begin
            errors++; $display("FAIL to_clear: timeout=%b arvalid=%b required 0 0", timeout, arvalid);
        end
        @(negedge clock); reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read();
        test_aw_stall();
        test_error_resp();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_uart_master.md
Name: axil_uart_master

Overview:
- AXI4-Lite initiator: turns a simple single-command request/response interface into AXI-Lite write and read transactions toward the UART register block (or any AXI-Lite slave).
- Lets on-chip logic (boot sequencer, loopback checker) program and poll the UART without a CPU.
- One outstanding transaction at a time; responses returned in order with AXI resp code.

Parameters:
P_M_AXI_DATA_WIDTH, 32, AXI data width (32 only supported)
P_M_AXI_ADDR_WIDTH, 16, AXI address width
P_TIMEOUT_CYCLES, 1024, watchdog limit per channel wait (used only with optional feature)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR  byte address
cmd_wdata  in  DATA  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA  read data (0 for writes)
rsp_resp  out  2  bresp/rresp captured from slave
m_axi_awaddr  out  ADDR
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr  out  ADDR
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  DATA
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1
timeout  out  1  sticky watchdog flag (optional feature; tied 0 otherwise)

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0 except cmd_ready=1; addr/data/rsp_* outputs 0; timeout 0. Reset mid-transaction aborts immediately to IDLE (system resets slave too).
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE: cmd_ready=1. On cmd_valid, register addr/wdata/write; next cycle (latency 1) enter WR_AW_W or RD_AR.
- WR_AW_W: awvalid and wvalid rise together. Each drops the cycle after its own handshake, independently; address/data held stable while valid. Go to WR_B when both handshakes done (either order, or same cycle).
- WR_B: bready=1; on bvalid capture bresp into rsp_resp, rsp_rdata=0, drop bready, go RSP.
- RD_AR: arvalid=1 until arready; then RD_R.
- RD_R: rready=1; on rvalid capture rdata/rresp, drop rready, go RSP.
- RSP: rsp_valid=1, payload stable until rsp_ready; then IDLE. cmd_ready=0 in every state other than IDLE, so back-to-back commands are spaced by ≥1 IDLE cycle.
- Valid signals never deasserted before handshake (AXI rule). Master never depends on slave ready to assert valid.
- Minimum write turnaround (zero-wait slave, rsp_ready=1): cmd accept N, AW/W N+1, B N+2, rsp_valid N+3.
- No wstrb/prot ports: slave interface defines none; full-word writes only.

Optional Feature:
AXIL_UART_MASTER_TIMEOUT_EN
- Defined: 16-bit counter resets on entry to WR_AW_W, WR_B, RD_AR, RD_R and on every handshake; on reaching P_TIMEOUT_CYCLES sets sticky timeout=1 (cleared only by reset). Transaction is NOT aborted (AXI forbids dropping valid); state machine keeps waiting.
- Undefined: no counter, timeout output driven 0.

Test Plan:
- Write cmd addr 0x0004 data 0x0000000C, zero-wait slave -> awaddr=0x0004, wdata=0x0C handshake at N+1, bready at N+2, rsp_valid N+3 with rsp_write=1, rsp_resp=00.
- Read cmd addr 0x0000, slave rvalid 3 cycles after arready with rdata=0x00000041 -> rsp_rdata=0x41, rsp_resp=00, rready high only in RD_R.
- Slave holds awready low 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles with stable addr, bready asserted only after AW done.
- Slave returns bresp=2'b10 then rresp=2'b11 -> rsp_resp=10 then 11; rsp held while rsp_ready low 4 cycles, cmd_ready=0 throughout.
- Assert reset during WR_B -> all AXI valids/readys 0 asynchronously, cmd_ready=1 after release, next command completes normally.
- With macro defined, P_TIMEOUT_CYCLES=16, arready never asserted -> timeout=1 after 16 cycles in RD_AR, arvalid still 1; without macro timeout stays 0.
